// File: rtl/nonlinear_transform_pipe.sv
// Purpose: rescale wide accumulator samples and apply a per-sample nonlinearity with output saturation.
// Latency: 3 cycles from input handshake to out_valid, plus one cycle per stall cycle.
// Backpressure: a single global advance; every stage holds when out_valid is set and out_ready is low.
module nonlinear_transform_pipe #(
  parameter int IN_WIDTH   = 32,
  parameter int IN_FRAC    = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int OUT_FRAC   = 8,
  parameter int CHAN_WIDTH = 2,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_sample,
  input  logic [CHAN_WIDTH-1:0] in_chan,
  input  logic [2:0]            transform_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_sample,
  output logic [CHAN_WIDTH-1:0] out_chan,
  output logic                  out_sat,
  input  logic                  clear_sat,
  output logic [15:0]           sat_count
);

  // One spare bit so that |v| of the most negative sample cannot overflow.
  localparam int VW    = IN_WIDTH + 1;
  localparam int SHIFT = IN_FRAC - OUT_FRAC;

  localparam logic signed [VW-1:0] ONE  = VW'(1) << OUT_FRAC;
  localparam logic signed [VW-1:0] HALF = VW'(1) << (OUT_FRAC - 1);
  localparam logic signed [VW-1:0] MAXV = (VW'(1) << (OUT_WIDTH - 1)) - VW'(1);
  localparam logic signed [VW-1:0] MINV = ~MAXV;

  logic advance;

  logic                  s1_vld_q;
  logic signed [VW-1:0]  s1_ext;
  logic signed [VW-1:0]  s1_v_d, s1_v_q;
  logic [CHAN_WIDTH-1:0] s1_chan_q;
  logic [2:0]            s1_sel_q;

  logic                  s2_vld_q;
  logic signed [VW-1:0]  s2_t;
  logic signed [VW-1:0]  s2_y_d, s2_y_q;
  logic [CHAN_WIDTH-1:0] s2_chan_q;

  logic                  out_vld_q;
  logic [OUT_WIDTH-1:0]  out_sample_d, out_sample_q;
  logic [CHAN_WIDTH-1:0] out_chan_q;
  logic                  out_sat_d, out_sat_q;
  logic [15:0]           sat_count_d, sat_count_q;

  assign advance    = !out_vld_q || out_ready;
  assign in_ready   = advance;
  assign out_valid  = out_vld_q;
  assign out_sample = out_sample_q;
  assign out_chan   = out_chan_q;
  assign out_sat    = out_sat_q;
  assign sat_count  = sat_count_q;

  // S1 datapath: sign-extend, then floor-shift down to the output fraction.
  always_comb begin
    s1_ext = {in_sample[IN_WIDTH-1], in_sample};
    s1_v_d = s1_ext >>> SHIFT;
  end

  // S1 register: tag and mode are captured only on an input handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_v_q    <= '0;
      s1_chan_q <= '0;
      s1_sel_q  <= '0;
    end else if (advance) begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        s1_v_q    <= s1_v_d;
        s1_chan_q <= in_chan;
        s1_sel_q  <= transform_sel;
      end
    end
  end

  // S2 datapath: selected nonlinearity on the rescaled value.
  always_comb begin
    s2_t   = (s1_v_q >>> 2) + HALF;
    s2_y_d = s1_v_q;
    case (s1_sel_q)
      3'b001: begin
        if (s2_t < 0)        s2_y_d = '0;
        else if (s2_t > ONE) s2_y_d = ONE;
        else                 s2_y_d = s2_t;
      end
      3'b010: begin
        if (s1_v_q > ONE)       s2_y_d = ONE;
        else if (s1_v_q < -ONE) s2_y_d = -ONE;
        else                    s2_y_d = s1_v_q;
      end
      3'b011:  s2_y_d = (s1_v_q < 0) ? '0 : s1_v_q;
      3'b100:  s2_y_d = (s1_v_q < 0) ? (s1_v_q >>> LEAK_SHIFT) : s1_v_q;
      3'b101:  s2_y_d = (s1_v_q < 0) ? -s1_v_q : s1_v_q;
      default: s2_y_d = s1_v_q;
    endcase
  end

  // S2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q  <= 1'b0;
      s2_y_q    <= '0;
      s2_chan_q <= '0;
    end else if (advance) begin
      s2_vld_q  <= s1_vld_q;
      s2_y_q    <= s2_y_d;
      s2_chan_q <= s1_chan_q;
    end
  end

  // S3 datapath: clamp to the output range and flag when clamping occurred.
  always_comb begin
    out_sat_d    = 1'b0;
    out_sample_d = s2_y_q[OUT_WIDTH-1:0];
    if (s2_y_q > MAXV) begin
      out_sat_d    = 1'b1;
      out_sample_d = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end else if (s2_y_q < MINV) begin
      out_sat_d    = 1'b1;
      out_sample_d = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end
  end

  // S3 / output register: holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q    <= 1'b0;
      out_sample_q <= '0;
      out_chan_q   <= '0;
      out_sat_q    <= 1'b0;
    end else if (advance) begin
      out_vld_q    <= s2_vld_q;
      out_sample_q <= out_sample_d;
      out_chan_q   <= s2_chan_q;
      out_sat_q    <= out_sat_d;
    end
  end

  // Saturation counter next state: clear dominates, increment sticks at all-ones.
  always_comb begin
    sat_count_d = sat_count_q;
    if (clear_sat) begin
      sat_count_d = '0;
    end else if (out_vld_q && out_ready && out_sat_q && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk) begin
    if (rst) sat_count_q <= '0;
    else     sat_count_q <= sat_count_d;
  end

endmodule

// File: tb/tb_nonlinear_transform_pipe.sv
// Purpose: directed, table-driven check of nonlinear_transform_pipe with default parameters.
// Latency: expects results 3 cycles after each input handshake when unstalled.
// Backpressure: drives an out_ready stall window and checks hold, ordering and in_ready.
module tb_nonlinear_transform_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sample;
  logic [1:0]  in_chan;
  logic [2:0]  transform_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sample;
  logic [1:0]  out_chan;
  logic        out_sat;
  logic        clear_sat;
  logic [15:0] sat_count;

  int total = 0;
  int bad   = 0;

  nonlinear_transform_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sample     (in_sample),
    .in_chan       (in_chan),
    .transform_sel (transform_sel),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sample    (out_sample),
    .out_chan      (out_chan),
    .out_sat       (out_sat),
    .clear_sat     (clear_sat),
    .sat_count     (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] smp;
    logic [2:0]  sel;
    logic [15:0] exp;
    logic        sat;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Waits for out_valid with a bound; returns the number of steps taken.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
  endtask

  initial begin
    int          exp_cnt;
    int          lat;
    int          n;
    logic [31:0] rnd;
    int          sent, rcvd, cyc, vcount;
    logic        hs_in, held_vld, saw_block;
    logic [15:0] held_s;
    logic [1:0]  held_c;
    logic        held_sat;

    vecs[0]  = '{32'h00018000, 3'b000, 16'h0180, 1'b0};
    vecs[1]  = '{32'h00C80000, 3'b000, 16'h7FFF, 1'b1};
    vecs[2]  = '{32'hFED40000, 3'b000, 16'h8000, 1'b1};
    vecs[3]  = '{32'h00000000, 3'b001, 16'h0080, 1'b0};
    vecs[4]  = '{32'h00080000, 3'b001, 16'h0100, 1'b0};
    vecs[5]  = '{32'hFFF80000, 3'b001, 16'h0000, 1'b0};
    vecs[6]  = '{32'h00030000, 3'b010, 16'h0100, 1'b0};
    vecs[7]  = '{32'h00008000, 3'b010, 16'h0080, 1'b0};
    vecs[8]  = '{32'hFFFE0000, 3'b011, 16'h0000, 1'b0};
    vecs[9]  = '{32'hFFFE0000, 3'b100, 16'hFFC0, 1'b0};
    vecs[10] = '{32'hFFFE0000, 3'b101, 16'h0200, 1'b0};
    vecs[11] = '{32'h80000000, 3'b101, 16'h7FFF, 1'b1};
    vecs[12] = '{32'h00018000, 3'b110, 16'h0180, 1'b0};
    vecs[13] = '{32'hFFFD0000, 3'b010, 16'hFF00, 1'b0};
    vecs[14] = '{32'hFFFFFFFF, 3'b000, 16'hFFFF, 1'b0};
    vecs[15] = '{32'hFFFFFF00, 3'b100, 16'hFFFF, 1'b0};
    vecs[16] = '{32'h7FFFFFFF, 3'b111, 16'h7FFF, 1'b1};
    vecs[17] = '{32'h00010000, 3'b011, 16'h0100, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_sample = '0; in_chan = '0;
    transform_sel = '0; out_ready = 1'b1; clear_sat = 1'b0;

    // Reset state
    step(); step();
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_sample", 32'(out_sample), 32'd0);
    chk("rst_out_chan",   32'(out_chan),   32'd0);
    chk("rst_out_sat",    32'(out_sat),    32'd0);
    chk("rst_sat_count",  32'(sat_count),  32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven single-sample vectors
    exp_cnt = 0;
    for (int i = 0; i < NV; i++) begin
      in_sample     = vecs[i].smp;
      transform_sel = vecs[i].sel;
      in_chan       = 2'(i);
      in_valid      = 1'b1;
      out_ready     = 1'b1;
      step();
      in_valid = 1'b0;
      rnd = $urandom;
      in_sample     = rnd;
      transform_sel = rnd[2:0];
      in_chan       = rnd[4:3];
      wait_out(n);
      lat = n + 1;
      chk($sformatf("vec%0d_latency", i), 32'(lat),        32'd3);
      chk($sformatf("vec%0d_sample", i),  32'(out_sample), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_sat", i),     32'(out_sat),    32'(vecs[i].sat));
      chk($sformatf("vec%0d_chan", i),    32'(out_chan),   32'(i % 4));
      if (vecs[i].sat) exp_cnt++;
    end
    step();
    chk("sat_count_after_vectors", 32'(sat_count), 32'(exp_cnt));

    // Clear on the same cycle as a saturating handshake
    in_sample = 32'h00C80000; transform_sel = 3'b000; in_chan = 2'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(n);
    chk("clr_out_sat", 32'(out_sat), 32'd1);
    clear_sat = 1'b1;
    step();
    clear_sat = 1'b0;
    chk("clr_wins_count", 32'(sat_count), 32'd0);
    in_sample = 32'hFED40000; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(n);
    step();
    chk("count_after_clear", 32'(sat_count), 32'd1);

    // Backpressure stream with an out_ready stall window
    sent = 0; rcvd = 0; cyc = 0; held_vld = 1'b0; saw_block = 1'b0;
    held_s = '0; held_c = '0; held_sat = 1'b0;
    while (rcvd < 10 && cyc < 60) begin
      out_ready     = !(cyc >= 4 && cyc <= 8);
      in_valid      = (sent < 10);
      in_sample     = 32'(sent) << 16;
      in_chan       = 2'(sent);
      transform_sel = 3'b000;
      #1;
      if (held_vld) begin
        chk($sformatf("stall_hold_sample_c%0d", cyc), 32'(out_sample), 32'(held_s));
        chk($sformatf("stall_hold_chan_c%0d", cyc),   32'(out_chan),   32'(held_c));
        chk($sformatf("stall_hold_sat_c%0d", cyc),    32'(out_sat),    32'(held_sat));
        chk($sformatf("stall_hold_valid_c%0d", cyc),  32'(out_valid),  32'd1);
      end
      if (in_valid && !in_ready) saw_block = 1'b1;
      hs_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk($sformatf("bp_sample%0d", rcvd), 32'(out_sample), 32'(16'(rcvd * 256)));
        chk($sformatf("bp_chan%0d", rcvd),   32'(out_chan),   32'(rcvd % 4));
        rcvd++;
      end
      held_vld = out_valid && !out_ready;
      held_s   = out_sample;
      held_c   = out_chan;
      held_sat = out_sat;
      @(posedge clk);
      #1;
      if (hs_in) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_in_ready_dropped", 32'(saw_block), 32'd1);
    chk("bp_received",         32'(rcvd),      32'd10);
    chk("bp_sent",             32'(sent),      32'd10);

    // Reset with three saturating samples in flight
    in_sample = 32'h00C80000; transform_sel = 3'b000; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_chan = 2'(k);
      step();
    end
    in_valid = 1'b0;
    chk("inflight_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid",  32'(out_valid),  32'd0);
    chk("midrst_out_sample", 32'(out_sample), 32'd0);
    chk("midrst_sat_count",  32'(sat_count),  32'd0);
    vcount = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (out_valid) vcount++;
    end
    chk("midrst_no_stale", 32'(vcount), 32'd0);
    chk("midrst_sat_count_hold", 32'(sat_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
